riscv_core_mul_pipelined: RTL and testbench
===========================================

RISCV_CORE_MUL_PIPELINED -- requirements
Module: riscv_core_mul_pipelined

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter STAGES, default 3, giving the number of pipeline register stages; legal values are 1 to 4.
REQ-003 The block SHALL have port i_mul_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_mul_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_mul_valid, input, 1 bit: upstream operation valid.
REQ-006 The block SHALL have port o_mul_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-007 The block SHALL have ports i_mul_srcA and i_mul_srcB, input, XLEN bits each: multiplicand and multiplier.
REQ-008 The block SHALL have port i_mul_control, input, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
REQ-009 The block SHALL have port i_mul_isword, input, 1 bit: 32-bit word operation (MULW); meaningful only when XLEN=64.
REQ-010 The block SHALL have port i_mul_flush, input, 1 bit: discard all in-flight operations.
REQ-011 The block SHALL have port o_mul_valid, output, 1 bit: o_mul_result is valid.
REQ-012 The block SHALL have port i_mul_ready, input, 1 bit: downstream accepts the result.
REQ-013 The block SHALL have port o_mul_result, output, XLEN bits: the selected product field.
REQ-014 The block SHALL have port o_mul_busy, output, 1 bit: at least one pipeline stage holds a valid operation.

Function
REQ-015 The block SHALL accept an operation when i_mul_valid=1 and o_mul_ready=1 in the same cycle.
REQ-016 o_mul_ready SHALL equal (!o_mul_valid || i_mul_ready) && !i_mul_flush.
REQ-017 The pipeline SHALL advance only when (!o_mul_valid || i_mul_ready), and all stages SHALL stall together otherwise.
REQ-018 An operation accepted at edge N SHALL present o_mul_valid=1 after edge N+STAGES-1 when no stall occurs; a stall adds exactly one cycle per stalled cycle.
REQ-019 Throughput SHALL be one operation per cycle with no bubbles inserted between back-to-back accepted operations.
REQ-020 Partial products SHALL be formed by radix-16 modified Booth encoding on XLEN+1-bit sign/zero-extended operands.
REQ-021 Partial products SHALL be reduced by a 4:2 compressor tree and a final carry-lookahead add.
REQ-022 The reduction SHALL be split across stages so that the last stage registers the final sum.
REQ-023 Operand extension SHALL be: MUL and MULH sign-extend both operands; MULHSU sign-extends srcA and zero-extends srcB; MULHU zero-extends both.
REQ-024 MUL SHALL return product[XLEN-1:0]; MULH, MULHSU and MULHU SHALL return product[2*XLEN-1:XLEN].
REQ-025 When i_mul_isword=1, the block SHALL multiply srcA[31:0] by srcB[31:0] and return the sign extension of product bit 31 down to bit 0 to XLEN bits, with i_mul_control ignored.
REQ-026 The control and isword fields SHALL travel with their operation through every stage.
REQ-027 While o_mul_valid=1 and i_mul_ready=0, o_mul_result and o_mul_valid SHALL remain unchanged.
REQ-028 When i_mul_flush=1, the block SHALL clear all stage valid bits and o_mul_valid at the next edge and SHALL accept nothing that cycle.
REQ-029 Flush SHALL take priority over a simultaneous downstream handshake; a result shown in the flush cycle with i_mul_ready=1 counts as consumed.
REQ-030 Data registers of invalid stages SHALL NOT be required to hold any particular value, except o_mul_result.

Reset
REQ-031 When i_mul_rst_n=0 at an edge, all stage valid bits, o_mul_valid and o_mul_busy SHALL become 0, and o_mul_result SHALL become 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations, with no o_mul_valid for them after reset is released.
REQ-033 o_mul_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-034 With XLEN=64, STAGES=3, MULHU 0xFFFF_FFFF_FFFF_FFFF x 0xFFFF_FFFF_FFFF_FFFF SHALL give result 0xFFFF_FFFF_FFFF_FFFE with o_mul_valid rising 3 cycles after acceptance.
REQ-035 MUL -1 x -1 SHALL give 0x1, and MULH -1 x -1 SHALL give 0x0.
REQ-036 MULHSU srcA=0xFFFF_FFFF_FFFF_FFFF, srcB=0x2 SHALL give 0xFFFF_FFFF_FFFF_FFFF.
REQ-037 MULW srcA=0x1234_5678_7FFF_FFFF, srcB=0x2 SHALL give 0xFFFF_FFFF_FFFF_FFFE.
REQ-038 Five back-to-back operations with i_mul_ready=0 for 3 cycles SHALL keep o_mul_ready=0 while stalled and deliver all five results in order with none lost or duplicated.
REQ-039 A flush with 2 operations in flight, and separately a reset with 2 operations in flight, SHALL produce no o_mul_valid for those operations, and a new operation afterwards SHALL complete with the correct latency.

Source files
------------

// File: rtl/riscv_core_mul_pipelined.sv
// Pipelined RV64M/RV32M multiplier: radix-16 Booth partial products, 4:2 compressor tree, carry-lookahead final add.
// Latency: STAGES cycles from acceptance to o_mul_valid; one operation per cycle sustained.
// Backpressure: all stages stall together while o_mul_valid && !i_mul_ready; i_mul_flush drops everything in flight.
//
// Ports:
//   i_mul_clk, i_mul_rst_n (sync, active-low)
//   i_mul_valid / o_mul_ready      : operation handshake (srcA, srcB, control, isword)
//   o_mul_valid / i_mul_ready      : result handshake (o_mul_result)
//   i_mul_flush                    : discard all in-flight operations
//   o_mul_busy                     : any stage holds a valid operation
module riscv_core_mul_pipelined #(
    parameter int XLEN   = 64,
    parameter int STAGES = 3
) (
    input  logic            i_mul_clk,
    input  logic            i_mul_rst_n,
    input  logic            i_mul_valid,
    output logic            o_mul_ready,
    input  logic [XLEN-1:0] i_mul_srcA,
    input  logic [XLEN-1:0] i_mul_srcB,
    input  logic [1:0]      i_mul_control,
    input  logic            i_mul_isword,
    input  logic            i_mul_flush,
    output logic            o_mul_valid,
    input  logic            i_mul_ready,
    output logic [XLEN-1:0] o_mul_result,
    output logic            o_mul_busy
);

    // All arithmetic is modulo 2^PW; only product bits [2*XLEN-1:0] are ever selected.
    localparam int PW   = 2 * XLEN;
    localparam int ND   = (XLEN + 4) / 4;          // Booth digits covering the XLEN+1-bit multiplier
    localparam int NPAD = (ND + 1 <= 16) ? 16 : 32; // Booth rows + negation-correction row, padded for the tree

    logic adv;
    logic acc;
    logic pipe_busy;

    assign adv         = !o_mul_valid || i_mul_ready;
    assign o_mul_ready = adv && !i_mul_flush;
    assign acc         = i_mul_valid && o_mul_ready;
    assign o_mul_busy  = o_mul_valid || pipe_busy;

    function automatic logic [2*PW-1:0] compress42(input logic [PW-1:0] w, x, y, z);
        logic [PW-1:0] s1, c1, s2, c2;
        s1 = w ^ x ^ y;
        c1 = ((w & x) | (w & y) | (x & y)) << 1;
        s2 = s1 ^ c1 ^ z;
        c2 = ((s1 & c1) | (s1 & z) | (c1 & z)) << 1;
        return {s2, c2};
    endfunction

    // Kogge-Stone prefix carry-lookahead adder.
    function automatic logic [PW-1:0] cla_add(input logic [PW-1:0] x, y);
        logic [PW-1:0] p, gg, pp;
        p  = x ^ y;
        gg = x & y;
        pp = p;
        for (int d = 1; d < PW; d = d * 2) begin
            gg = gg | (pp & (gg << d));
            pp = pp & (pp << d);
        end
        return p ^ {gg[PW-2:0], 1'b0};
    endfunction

    // ---------------- front end: operand extension, Booth rows, tree down to 4 terms
    logic [PW-1:0] front_t [4];

    always_comb begin
        logic [XLEN:0]   a_ext;
        logic [XLEN:0]   b_ext;
        logic [4*ND:0]   b_booth;
        logic [PW-1:0]   mult [0:8];
        logic [PW-1:0]   tree [NPAD];
        logic [PW-1:0]   corr;
        logic [4:0]      win;
        logic            neg;
        logic [3:0]      mag;
        int              d;

        if (i_mul_isword) begin
            // Only the low 32 product bits are used, so the extension choice is irrelevant.
            a_ext = (XLEN+1)'($signed(i_mul_srcA[31:0]));
            b_ext = (XLEN+1)'($signed(i_mul_srcB[31:0]));
        end else begin
            a_ext = {(i_mul_control != 2'b11) & i_mul_srcA[XLEN-1], i_mul_srcA};
            b_ext = {!i_mul_control[1] & i_mul_srcB[XLEN-1], i_mul_srcB};
        end

        mult[0] = '0;
        mult[1] = PW'($signed(a_ext));
        mult[2] = mult[1] << 1;
        mult[3] = mult[1] + mult[2];
        mult[4] = mult[1] << 2;
        mult[5] = mult[1] + mult[4];
        mult[6] = mult[3] << 1;
        mult[8] = mult[1] << 3;
        mult[7] = mult[8] - mult[1];

        b_booth = {{(4*ND-XLEN-1){b_ext[XLEN]}}, b_ext, 1'b0};
        corr    = '0;
        for (int k = 0; k < NPAD; k++) tree[k] = '0;

        for (int i = 0; i < ND; i++) begin
            win = b_booth[4*i +: 5];
            d   = int'(win[0]) + int'(win[1]) + 2 * int'(win[2]) + 4 * int'(win[3]) - 8 * int'(win[4]);
            neg = (d < 0);
            mag = neg ? 4'(-d) : 4'(d);
            // Negative digits use one's complement here; the +1 lands in the correction row.
            tree[i]    = (mult[mag] ^ {PW{neg}}) << (4 * i);
            corr[4*i]  = neg;
        end
        tree[ND] = corr;

        // Each level turns groups of four rows into two until four remain.
        for (int n = NPAD; n > 4; n = n / 2) begin
            for (int j = 0; j < n / 4; j++) begin
                {tree[2*j], tree[2*j+1]} = compress42(tree[4*j], tree[4*j+1], tree[4*j+2], tree[4*j+3]);
            end
        end

        for (int k = 0; k < 4; k++) front_t[k] = tree[k];
    end

    // ---------------- pipeline stages feeding the final adder
    logic [PW-1:0] fin0, fin1;
    logic          fin_vld;
    logic [1:0]    fin_ctl;
    logic          fin_isw;

    if (STAGES >= 3) begin : g_deep
        logic [PW-1:0] s1_t [4];
        logic          s1_vld;
        logic [1:0]    s1_ctl;
        logic          s1_isw;
        logic [PW-1:0] s2_in0, s2_in1, s2_t0, s2_t1;
        logic          s2_vld;
        logic [1:0]    s2_ctl;
        logic          s2_isw;

        always_ff @(posedge i_mul_clk) begin
            if (!i_mul_rst_n || i_mul_flush) begin
                s1_vld <= 1'b0;
                s2_vld <= 1'b0;
            end else if (adv) begin
                s1_vld <= acc;
                s2_vld <= s1_vld;
            end
        end

        assign {s2_in0, s2_in1} = compress42(s1_t[0], s1_t[1], s1_t[2], s1_t[3]);

        always_ff @(posedge i_mul_clk) begin
            if (adv) begin
                s1_t   <= front_t;
                s1_ctl <= i_mul_control;
                s1_isw <= i_mul_isword;
                s2_t0  <= s2_in0;
                s2_t1  <= s2_in1;
                s2_ctl <= s1_ctl;
                s2_isw <= s1_isw;
            end
        end

        if (STAGES >= 4) begin : g_extra
            // Extra register ahead of the adder; gives retiming room for the wide CLA.
            logic [PW-1:0] s3_t0, s3_t1;
            logic          s3_vld;
            logic [1:0]    s3_ctl;
            logic          s3_isw;

            always_ff @(posedge i_mul_clk) begin
                if (!i_mul_rst_n || i_mul_flush) s3_vld <= 1'b0;
                else if (adv)                    s3_vld <= s2_vld;
            end

            always_ff @(posedge i_mul_clk) begin
                if (adv) begin
                    s3_t0  <= s2_t0;
                    s3_t1  <= s2_t1;
                    s3_ctl <= s2_ctl;
                    s3_isw <= s2_isw;
                end
            end

            assign fin0      = s3_t0;
            assign fin1      = s3_t1;
            assign fin_vld   = s3_vld;
            assign fin_ctl   = s3_ctl;
            assign fin_isw   = s3_isw;
            assign pipe_busy = s1_vld || s2_vld || s3_vld;
        end else begin : g_no_extra
            assign fin0      = s2_t0;
            assign fin1      = s2_t1;
            assign fin_vld   = s2_vld;
            assign fin_ctl   = s2_ctl;
            assign fin_isw   = s2_isw;
            assign pipe_busy = s1_vld || s2_vld;
        end
    end else if (STAGES == 2) begin : g_two
        logic [PW-1:0] s2_in0, s2_in1, s2_t0, s2_t1;
        logic          s2_vld;
        logic [1:0]    s2_ctl;
        logic          s2_isw;

        assign {s2_in0, s2_in1} = compress42(front_t[0], front_t[1], front_t[2], front_t[3]);

        always_ff @(posedge i_mul_clk) begin
            if (!i_mul_rst_n || i_mul_flush) s2_vld <= 1'b0;
            else if (adv)                    s2_vld <= acc;
        end

        always_ff @(posedge i_mul_clk) begin
            if (adv) begin
                s2_t0  <= s2_in0;
                s2_t1  <= s2_in1;
                s2_ctl <= i_mul_control;
                s2_isw <= i_mul_isword;
            end
        end

        assign fin0      = s2_t0;
        assign fin1      = s2_t1;
        assign fin_vld   = s2_vld;
        assign fin_ctl   = s2_ctl;
        assign fin_isw   = s2_isw;
        assign pipe_busy = s2_vld;
    end else begin : g_one
        assign {fin0, fin1} = compress42(front_t[0], front_t[1], front_t[2], front_t[3]);
        assign fin_vld      = acc;
        assign fin_ctl      = i_mul_control;
        assign fin_isw      = i_mul_isword;
        assign pipe_busy    = 1'b0;
    end

    // ---------------- final add, field select, output register
    logic [PW-1:0]   prod;
    logic [XLEN-1:0] res;

    assign prod = cla_add(fin0, fin1);

    always_comb begin
        res = prod[2*XLEN-1:XLEN];
        if (fin_isw)                 res = XLEN'($signed(prod[31:0]));
        else if (fin_ctl == 2'b00)   res = prod[XLEN-1:0];
    end

    always_ff @(posedge i_mul_clk) begin
        if (!i_mul_rst_n) begin
            o_mul_valid  <= 1'b0;
            o_mul_result <= '0;
        end else if (i_mul_flush) begin
            o_mul_valid <= 1'b0;
        end else if (adv) begin
            o_mul_valid <= fin_vld;
            // Result holds its last delivered value while no new operation arrives.
            if (fin_vld) o_mul_result <= res;
        end
    end

endmodule

// File: tb/tb_riscv_core_mul_pipelined.sv
module tb_riscv_core_mul_pipelined;

    logic        i_mul_clk = 1'b0;
    logic        i_mul_rst_n;
    logic        i_mul_valid;
    logic        o_mul_ready;
    logic [63:0] i_mul_srcA;
    logic [63:0] i_mul_srcB;
    logic [1:0]  i_mul_control;
    logic        i_mul_isword;
    logic        i_mul_flush;
    logic        o_mul_valid;
    logic        i_mul_ready;
    logic [63:0] o_mul_result;
    logic        o_mul_busy;

    always #5 i_mul_clk = ~i_mul_clk;

    riscv_core_mul_pipelined #(.XLEN(64), .STAGES(3)) dut (
        .i_mul_clk     (i_mul_clk),
        .i_mul_rst_n   (i_mul_rst_n),
        .i_mul_valid   (i_mul_valid),
        .o_mul_ready   (o_mul_ready),
        .i_mul_srcA    (i_mul_srcA),
        .i_mul_srcB    (i_mul_srcB),
        .i_mul_control (i_mul_control),
        .i_mul_isword  (i_mul_isword),
        .i_mul_flush   (i_mul_flush),
        .o_mul_valid   (o_mul_valid),
        .i_mul_ready   (i_mul_ready),
        .o_mul_result  (o_mul_result),
        .o_mul_busy    (o_mul_busy)
    );

    int          n_vec    = 0;
    int          n_bad    = 0;
    int          n_out    = 0;
    int          rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    logic [63:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [63:0] model(input logic [63:0] a, b, input logic [1:0] c, input logic w);
        logic [129:0] ea, eb, p;
        logic [63:0]  lp;
        logic         sa, sb;
        if (w) begin
            lp = {32'b0, a[31:0]} * {32'b0, b[31:0]};
            return {{32{lp[31]}}, lp[31:0]};
        end
        sa = (c != 2'b11) && a[63];
        sb = !c[1] && b[63];
        ea = {{66{sa}}, a};
        eb = {{66{sb}}, b};
        p  = ea * eb;
        return (c == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(5))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Downstream ready, updated just after each rising edge.
    always @(posedge i_mul_clk) begin
        #1;
        case (rdy_mode)
            0:       i_mul_ready = 1'b1;
            1:       i_mul_ready = ($urandom_range(3) != 0);
            default: i_mul_ready = 1'b0;
        endcase
    end

    // Scoreboard: every shown result must be expected; consumed results are compared in order.
    always @(negedge i_mul_clk) begin
        if (i_mul_rst_n === 1'b1 && o_mul_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_valid", {63'b0, o_mul_valid}, 64'd0);
            end else if (i_mul_ready) begin
                check("result", o_mul_result, exp_q.pop_front());
                n_out++;
            end
        end
    end

    task automatic send(input logic [63:0] a, b, input logic [1:0] c, input logic w, input logic [63:0] e);
        int t = 0;
        i_mul_valid   = 1'b1;
        i_mul_srcA    = a;
        i_mul_srcB    = b;
        i_mul_control = c;
        i_mul_isword  = w;
        @(negedge i_mul_clk);
        while (!o_mul_ready && t < 200) begin
            t++;
            @(negedge i_mul_clk);
        end
        if (!o_mul_ready) check("accept_timeout", {63'b0, o_mul_ready}, 64'd1);
        else              exp_q.push_back(e);
        @(posedge i_mul_clk);
        #1;
        i_mul_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [63:0] a, b;
        logic [1:0]  c;
        logic        w;
        a = pick();
        b = pick();
        c = 2'($urandom_range(3));
        w = ($urandom_range(3) == 0);
        send(a, b, c, w, model(a, b, c, w));
    endtask

    // Called right after the accepting edge: counts cycles until o_mul_valid.
    task automatic lat_check(input string tag, input int want);
        int k = 0;
        do begin
            @(negedge i_mul_clk);
            k++;
        end while (!o_mul_valid && k < 20);
        check(tag, 64'(k), 64'(want));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge i_mul_clk);
            t++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge i_mul_clk);
        #1;
    endtask

    initial begin
        int n0;
        i_mul_rst_n   = 1'b0;
        i_mul_valid   = 1'b0;
        i_mul_flush   = 1'b0;
        i_mul_srcA    = '0;
        i_mul_srcB    = '0;
        i_mul_control = 2'b00;
        i_mul_isword  = 1'b0;

        // Reset state
        repeat (2) @(posedge i_mul_clk);
        @(negedge i_mul_clk);
        check("rst_valid",  {63'b0, o_mul_valid}, 64'd0);
        check("rst_busy",   {63'b0, o_mul_busy},  64'd0);
        check("rst_result", o_mul_result,         64'd0);
        @(posedge i_mul_clk);
        #1 i_mul_rst_n = 1'b1;
        @(negedge i_mul_clk);
        check("ready_after_rst", {63'b0, o_mul_ready}, 64'd1);
        @(posedge i_mul_clk);
        #1;

        // Latency and directed values
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        lat_check("lat_mulhu", 3);
        drain();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 1'b0, 64'h1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 1'b0, 64'h0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h2,                   2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h1234_5678_7FFF_FFFF, 64'h2,                   2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        drain();

        // Random mix under random downstream backpressure
        rdy_mode = 1;
        for (int i = 0; i < 60; i++) send_rand();
        rdy_mode = 0;
        drain();

        // Five back-to-back operations with a three-cycle downstream stall
        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 5; i++) send_rand();
            end
            begin
                int t = 0;
                do begin
                    @(negedge i_mul_clk);
                    t++;
                end while (!o_mul_valid && t < 50);
                rdy_mode = 2;
                @(posedge i_mul_clk);
                repeat (3) begin
                    @(negedge i_mul_clk);
                    check("stall_ready", {63'b0, o_mul_ready}, 64'd0);
                    check("stall_valid", {63'b0, o_mul_valid}, 64'd1);
                    check("stall_hold",  o_mul_result,         exp_q[0]);
                end
                rdy_mode = 0;
            end
        join
        drain();
        check("b2b_count", 64'(n_out - n0), 64'd5);

        // Flush with two operations in flight
        send_rand();
        send_rand();
        i_mul_flush = 1'b1;
        i_mul_valid = 1'b1;
        i_mul_srcA  = 64'h5;
        i_mul_srcB  = 64'h7;
        @(negedge i_mul_clk);
        check("flush_ready", {63'b0, o_mul_ready}, 64'd0);
        check("flush_busy",  {63'b0, o_mul_busy},  64'd1);
        @(posedge i_mul_clk);
        #1;
        i_mul_flush = 1'b0;
        i_mul_valid = 1'b0;
        exp_q.delete();
        @(negedge i_mul_clk);
        check("flush_busy_clr",  {63'b0, o_mul_busy},  64'd0);
        check("flush_valid_clr", {63'b0, o_mul_valid}, 64'd0);
        repeat (6) @(negedge i_mul_clk);
        @(posedge i_mul_clk);
        #1;
        send(64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF7);
        lat_check("lat_after_flush", 3);
        drain();

        // Reset with two operations in flight
        send_rand();
        send_rand();
        i_mul_rst_n = 1'b0;
        @(posedge i_mul_clk);
        #1;
        i_mul_rst_n = 1'b1;
        exp_q.delete();
        @(negedge i_mul_clk);
        check("rst2_valid",  {63'b0, o_mul_valid}, 64'd0);
        check("rst2_busy",   {63'b0, o_mul_busy},  64'd0);
        check("rst2_result", o_mul_result,         64'd0);
        check("rst2_ready",  {63'b0, o_mul_ready}, 64'd1);
        repeat (6) @(negedge i_mul_clk);
        @(posedge i_mul_clk);
        #1;
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0, 64'h4000_0000_0000_0000);
        lat_check("lat_after_rst", 3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
